// File: rtl/rename_table_if.sv
// Rename-stage bundle between the front end/freelist/commit side (master)
// and the speculative register alias table (slave).
interface rename_table_if #(
    parameter int unsigned ArchSel = 5,
    parameter int unsigned PhysSel = 6
) ();
    logic               stall;
    logic               prmiss;
    logic               valid_1;
    logic               valid_2;
    logic               wr_1;
    logic               wr_2;
    logic [ArchSel-1:0] src1_1;
    logic [ArchSel-1:0] src2_1;
    logic [ArchSel-1:0] dst_1;
    logic [ArchSel-1:0] src1_2;
    logic [ArchSel-1:0] src2_2;
    logic [ArchSel-1:0] dst_2;
    logic [PhysSel-1:0] alloc_1;
    logic [PhysSel-1:0] alloc_2;
    logic               alloc_valid_1;
    logic               alloc_valid_2;
    logic               com_valid_1;
    logic               com_valid_2;
    logic [ArchSel-1:0] com_dst_1;
    logic [ArchSel-1:0] com_dst_2;
    logic [PhysSel-1:0] com_tag_1;
    logic [PhysSel-1:0] com_tag_2;
    logic               out_valid_1;
    logic               out_valid_2;
    logic [PhysSel-1:0] psrc1_1;
    logic [PhysSel-1:0] psrc2_1;
    logic [PhysSel-1:0] pdst_1;
    logic [PhysSel-1:0] pold_1;
    logic [PhysSel-1:0] psrc1_2;
    logic [PhysSel-1:0] psrc2_2;
    logic [PhysSel-1:0] pdst_2;
    logic [PhysSel-1:0] pold_2;

    modport master (
        output stall, prmiss, valid_1, valid_2, wr_1, wr_2,
        output src1_1, src2_1, dst_1, src1_2, src2_2, dst_2,
        output alloc_1, alloc_2, alloc_valid_1, alloc_valid_2,
        output com_valid_1, com_valid_2, com_dst_1, com_dst_2, com_tag_1, com_tag_2,
        input  out_valid_1, out_valid_2,
        input  psrc1_1, psrc2_1, pdst_1, pold_1, psrc1_2, psrc2_2, pdst_2, pold_2
    );

    modport slave (
        input  stall, prmiss, valid_1, valid_2, wr_1, wr_2,
        input  src1_1, src2_1, dst_1, src1_2, src2_2, dst_2,
        input  alloc_1, alloc_2, alloc_valid_1, alloc_valid_2,
        input  com_valid_1, com_valid_2, com_dst_1, com_dst_2, com_tag_1, com_tag_2,
        output out_valid_1, out_valid_2,
        output psrc1_1, psrc2_1, pdst_1, pold_1, psrc1_2, psrc2_2, pdst_2, pold_2
    );
endinterface

// File: rtl/rename_table.sv
// Two-wide speculative register alias table with a committed shadow copy used
// to restore the speculative map on branch misprediction. Results are registered.
module rename_table #(
    parameter int unsigned NumArch = 32,
    parameter int unsigned ArchSel = 5,
    parameter int unsigned PhysSel = 6
) (
    input logic         clk,
    input logic         reset,
    rename_table_if.slave rif
);
    typedef logic [PhysSel-1:0] tag_t;

    tag_t spec_map_q [NumArch];
    tag_t spec_map_d [NumArch];
    tag_t com_map_q  [NumArch];
    tag_t com_map_d  [NumArch];

    logic wr1_eff, wr2_eff, fire_1, fire_2, byp_1;
    tag_t psrc1_1_d, psrc2_1_d, pdst_1_d, pold_1_d;
    tag_t psrc1_2_d, psrc2_2_d, pdst_2_d, pold_2_d;

    logic out_valid_1_q, out_valid_2_q;
    tag_t psrc1_1_q, psrc2_1_q, pdst_1_q, pold_1_q;
    tag_t psrc1_2_q, psrc2_2_q, pdst_2_q, pold_2_q;

    // A write to r0 is a non-write: r0 stays hard-mapped to tag 0.
    assign wr1_eff = rif.wr_1 && (rif.dst_1 != '0);
    assign wr2_eff = rif.wr_2 && (rif.dst_2 != '0);
    assign fire_1  = rif.valid_1 && !rif.stall && !rif.prmiss && (!wr1_eff || rif.alloc_valid_1);
    assign fire_2  = rif.valid_2 && !rif.stall && !rif.prmiss && (!wr2_eff || rif.alloc_valid_2)
                     && (fire_1 || !rif.valid_1);
    assign byp_1   = fire_1 && wr1_eff;

    always_comb begin
        psrc1_1_d = spec_map_q[rif.src1_1];
        psrc2_1_d = spec_map_q[rif.src2_1];
        pold_1_d  = wr1_eff ? spec_map_q[rif.dst_1] : (rif.dst_1 == '0 ? '0 : spec_map_q[rif.dst_1]);
        pdst_1_d  = wr1_eff ? rif.alloc_1 : '0;
        psrc1_2_d = (byp_1 && rif.src1_2 == rif.dst_1) ? rif.alloc_1 : spec_map_q[rif.src1_2];
        psrc2_2_d = (byp_1 && rif.src2_2 == rif.dst_1) ? rif.alloc_1 : spec_map_q[rif.src2_2];
        pold_2_d  = (byp_1 && rif.dst_2 == rif.dst_1) ? rif.alloc_1 : spec_map_q[rif.dst_2];
        pdst_2_d  = wr2_eff ? rif.alloc_2 : '0;
    end

    always_comb begin
        com_map_d = com_map_q;
        if (rif.com_valid_1 && rif.com_dst_1 != '0) com_map_d[rif.com_dst_1] = rif.com_tag_1;
        if (rif.com_valid_2 && rif.com_dst_2 != '0) com_map_d[rif.com_dst_2] = rif.com_tag_2;
        spec_map_d = spec_map_q;
        // Restore sees this cycle's commits so nothing retiring now is lost.
        if (rif.prmiss) begin
            spec_map_d = com_map_d;
        end else begin
            if (byp_1)             spec_map_d[rif.dst_1] = rif.alloc_1;
            if (fire_2 && wr2_eff) spec_map_d[rif.dst_2] = rif.alloc_2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NumArch; r++) begin
                spec_map_q[r] <= tag_t'(r);
                com_map_q[r]  <= tag_t'(r);
            end
            out_valid_1_q <= 1'b0;
            out_valid_2_q <= 1'b0;
            psrc1_1_q <= '0; psrc2_1_q <= '0; pdst_1_q <= '0; pold_1_q <= '0;
            psrc1_2_q <= '0; psrc2_2_q <= '0; pdst_2_q <= '0; pold_2_q <= '0;
        end else begin
            spec_map_q <= spec_map_d;
            com_map_q  <= com_map_d;
            if (rif.prmiss) begin
                out_valid_1_q <= 1'b0;
                out_valid_2_q <= 1'b0;
            end else if (!rif.stall) begin
                out_valid_1_q <= fire_1;
                out_valid_2_q <= fire_2;
                if (fire_1) begin
                    psrc1_1_q <= psrc1_1_d; psrc2_1_q <= psrc2_1_d;
                    pdst_1_q  <= pdst_1_d;  pold_1_q  <= pold_1_d;
                end
                if (fire_2) begin
                    psrc1_2_q <= psrc1_2_d; psrc2_2_q <= psrc2_2_d;
                    pdst_2_q  <= pdst_2_d;  pold_2_q  <= pold_2_d;
                end
            end
        end
    end

    assign rif.out_valid_1 = out_valid_1_q;
    assign rif.out_valid_2 = out_valid_2_q;
    assign rif.psrc1_1 = psrc1_1_q;
    assign rif.psrc2_1 = psrc2_1_q;
    assign rif.pdst_1  = pdst_1_q;
    assign rif.pold_1  = pold_1_q;
    assign rif.psrc1_2 = psrc1_2_q;
    assign rif.psrc2_2 = psrc2_2_q;
    assign rif.pdst_2  = pdst_2_q;
    assign rif.pold_2  = pold_2_q;
endmodule

// File: tb/tb_rename_table.sv
// Directed bench for rename_table: rename, intra-group bypass, blocking, stall,
// commit and misprediction restore, r0 handling.
module tb_rename_table;
    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    rename_table_if rif ();

    rename_table dut (
        .clk   (clk),
        .reset (reset),
        .rif   (rif)
    );

    task automatic clear_inputs();
        rif.stall = 0; rif.prmiss = 0;
        rif.valid_1 = 0; rif.valid_2 = 0; rif.wr_1 = 0; rif.wr_2 = 0;
        rif.src1_1 = 0; rif.src2_1 = 0; rif.dst_1 = 0;
        rif.src1_2 = 0; rif.src2_2 = 0; rif.dst_2 = 0;
        rif.alloc_1 = 0; rif.alloc_2 = 0; rif.alloc_valid_1 = 0; rif.alloc_valid_2 = 0;
        rif.com_valid_1 = 0; rif.com_valid_2 = 0;
        rif.com_dst_1 = 0; rif.com_dst_2 = 0; rif.com_tag_1 = 0; rif.com_tag_2 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic lookup(input logic [4:0] a, input logic [4:0] b);
        rif.valid_1 = 1; rif.src1_1 = a; rif.src2_1 = b;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        tests_run += 4;
        if (rif.out_valid_1 !== 1'b0) begin tests_failed++;
            $display("FAIL reset_ov1 got %0b want 0", rif.out_valid_1); end
        if (rif.out_valid_2 !== 1'b0) begin tests_failed++;
            $display("FAIL reset_ov2 got %0b want 0", rif.out_valid_2); end
        if (rif.psrc1_1 !== 6'd0) begin tests_failed++;
            $display("FAIL reset_psrc1_1 got %0d want 0", rif.psrc1_1); end
        if (rif.pold_2 !== 6'd0) begin tests_failed++;
            $display("FAIL reset_pold_2 got %0d want 0", rif.pold_2); end
    endtask

    task automatic test_basic();
        lookup(5'd3, 5'd4);
        tests_run += 4;
        if (rif.out_valid_1 !== 1'b1) begin tests_failed++;
            $display("FAIL basic_ov1 got %0b want 1", rif.out_valid_1); end
        if (rif.out_valid_2 !== 1'b0) begin tests_failed++;
            $display("FAIL basic_ov2 got %0b want 0", rif.out_valid_2); end
        if (rif.psrc1_1 !== 6'd3) begin tests_failed++;
            $display("FAIL basic_psrc1 got %0d want 3", rif.psrc1_1); end
        if (rif.psrc2_1 !== 6'd4) begin tests_failed++;
            $display("FAIL basic_psrc2 got %0d want 4", rif.psrc2_1); end
    endtask

    task automatic test_bypass();
        rif.valid_1 = 1; rif.wr_1 = 1; rif.dst_1 = 5; rif.alloc_1 = 40; rif.alloc_valid_1 = 1;
        rif.src1_1 = 5; rif.src2_1 = 6;
        rif.valid_2 = 1; rif.wr_2 = 1; rif.dst_2 = 5; rif.alloc_2 = 41; rif.alloc_valid_2 = 1;
        rif.src1_2 = 5; rif.src2_2 = 1;
        step();
        tests_run += 8;
        if (rif.out_valid_2 !== 1'b1) begin tests_failed++;
            $display("FAIL byp_ov2 got %0b want 1", rif.out_valid_2); end
        if (rif.psrc1_1 !== 6'd5) begin tests_failed++;
            $display("FAIL byp_psrc1_1 got %0d want 5", rif.psrc1_1); end
        if (rif.pdst_1 !== 6'd40) begin tests_failed++;
            $display("FAIL byp_pdst_1 got %0d want 40", rif.pdst_1); end
        if (rif.pold_1 !== 6'd5) begin tests_failed++;
            $display("FAIL byp_pold_1 got %0d want 5", rif.pold_1); end
        if (rif.psrc1_2 !== 6'd40) begin tests_failed++;
            $display("FAIL byp_psrc1_2 got %0d want 40", rif.psrc1_2); end
        if (rif.psrc2_2 !== 6'd1) begin tests_failed++;
            $display("FAIL byp_psrc2_2 got %0d want 1", rif.psrc2_2); end
        if (rif.pdst_2 !== 6'd41) begin tests_failed++;
            $display("FAIL byp_pdst_2 got %0d want 41", rif.pdst_2); end
        if (rif.pold_2 !== 6'd40) begin tests_failed++;
            $display("FAIL byp_pold_2 got %0d want 40", rif.pold_2); end
    endtask

    task automatic test_back_to_back();
        lookup(5'd5, 5'd0);
        tests_run += 2;
        if (rif.psrc1_1 !== 6'd41) begin tests_failed++;
            $display("FAIL b2b_r5 got %0d want 41", rif.psrc1_1); end
        if (rif.psrc2_1 !== 6'd0) begin tests_failed++;
            $display("FAIL b2b_r0 got %0d want 0", rif.psrc2_1); end
    endtask

    task automatic test_alloc_block();
        rif.valid_1 = 1; rif.wr_1 = 1; rif.dst_1 = 8; rif.alloc_1 = 50; rif.alloc_valid_1 = 0;
        rif.valid_2 = 1; rif.wr_2 = 0; rif.src1_2 = 3;
        step();
        tests_run += 3;
        if (rif.out_valid_1 !== 1'b0) begin tests_failed++;
            $display("FAIL blk_ov1 got %0b want 0", rif.out_valid_1); end
        if (rif.out_valid_2 !== 1'b0) begin tests_failed++;
            $display("FAIL blk_ov2 got %0b want 0", rif.out_valid_2); end
        if (rif.psrc1_1 !== 6'd41) begin tests_failed++;
            $display("FAIL blk_hold got %0d want 41", rif.psrc1_1); end
        lookup(5'd8, 5'd3);
        tests_run++;
        if (rif.psrc1_1 !== 6'd8) begin tests_failed++;
            $display("FAIL blk_r8 got %0d want 8", rif.psrc1_1); end
    endtask

    task automatic test_stall();
        lookup(5'd5, 5'd3);
        rif.stall = 1;
        rif.valid_1 = 1; rif.wr_1 = 1; rif.dst_1 = 5; rif.alloc_1 = 60; rif.alloc_valid_1 = 1;
        rif.src1_1 = 9;
        rif.valid_2 = 1; rif.src1_2 = 4;
        rif.com_valid_1 = 1; rif.com_dst_1 = 7; rif.com_tag_1 = 50;
        step();
        tests_run += 3;
        if (rif.out_valid_1 !== 1'b1) begin tests_failed++;
            $display("FAIL stall_ov1 got %0b want 1", rif.out_valid_1); end
        if (rif.psrc1_1 !== 6'd41) begin tests_failed++;
            $display("FAIL stall_psrc1 got %0d want 41", rif.psrc1_1); end
        if (rif.pdst_1 !== 6'd0) begin tests_failed++;
            $display("FAIL stall_pdst got %0d want 0", rif.pdst_1); end
        lookup(5'd5, 5'd7);
        tests_run += 2;
        if (rif.psrc1_1 !== 6'd41) begin tests_failed++;
            $display("FAIL stall_r5 got %0d want 41", rif.psrc1_1); end
        if (rif.psrc2_1 !== 6'd7) begin tests_failed++;
            $display("FAIL stall_r7spec got %0d want 7", rif.psrc2_1); end
        rif.prmiss = 1;
        step();
        tests_run++;
        if (rif.out_valid_1 !== 1'b0) begin tests_failed++;
            $display("FAIL prmiss_ov1 got %0b want 0", rif.out_valid_1); end
        lookup(5'd7, 5'd5);
        tests_run += 2;
        if (rif.psrc1_1 !== 6'd50) begin tests_failed++;
            $display("FAIL restore_r7 got %0d want 50", rif.psrc1_1); end
        if (rif.psrc2_1 !== 6'd5) begin tests_failed++;
            $display("FAIL restore_r5 got %0d want 5", rif.psrc2_1); end
    endtask

    task automatic test_prmiss_commit();
        rif.prmiss = 1;
        rif.valid_1 = 1; rif.wr_1 = 1; rif.dst_1 = 9; rif.alloc_1 = 45; rif.alloc_valid_1 = 1;
        rif.com_valid_1 = 1; rif.com_dst_1 = 2; rif.com_tag_1 = 33;
        rif.com_valid_2 = 1; rif.com_dst_2 = 11; rif.com_tag_2 = 20;
        step();
        tests_run++;
        if (rif.out_valid_1 !== 1'b0) begin tests_failed++;
            $display("FAIL pmc_ov1 got %0b want 0", rif.out_valid_1); end
        lookup(5'd9, 5'd2);
        tests_run += 2;
        if (rif.psrc1_1 !== 6'd9) begin tests_failed++;
            $display("FAIL pmc_r9 got %0d want 9", rif.psrc1_1); end
        if (rif.psrc2_1 !== 6'd33) begin tests_failed++;
            $display("FAIL pmc_r2 got %0d want 33", rif.psrc2_1); end
        // Same destination on both commit ports: port 2 is younger and wins.
        rif.com_valid_1 = 1; rif.com_dst_1 = 11; rif.com_tag_1 = 21;
        rif.com_valid_2 = 1; rif.com_dst_2 = 11; rif.com_tag_2 = 22;
        step();
        rif.prmiss = 1;
        step();
        lookup(5'd11, 5'd2);
        tests_run += 2;
        if (rif.psrc1_1 !== 6'd22) begin tests_failed++;
            $display("FAIL com_port2_wins got %0d want 22", rif.psrc1_1); end
        if (rif.psrc2_1 !== 6'd33) begin tests_failed++;
            $display("FAIL com_keep_r2 got %0d want 33", rif.psrc2_1); end
    endtask

    task automatic test_r0();
        rif.valid_1 = 1; rif.wr_1 = 1; rif.dst_1 = 0; rif.alloc_1 = 44; rif.alloc_valid_1 = 1;
        rif.src1_1 = 0; rif.src2_1 = 2;
        rif.valid_2 = 1; rif.src1_2 = 0; rif.dst_2 = 0;
        step();
        tests_run += 5;
        if (rif.out_valid_1 !== 1'b1) begin tests_failed++;
            $display("FAIL r0_ov1 got %0b want 1", rif.out_valid_1); end
        if (rif.pdst_1 !== 6'd0) begin tests_failed++;
            $display("FAIL r0_pdst got %0d want 0", rif.pdst_1); end
        if (rif.pold_1 !== 6'd0) begin tests_failed++;
            $display("FAIL r0_pold got %0d want 0", rif.pold_1); end
        if (rif.psrc2_1 !== 6'd33) begin tests_failed++;
            $display("FAIL r0_psrc2 got %0d want 33", rif.psrc2_1); end
        if (rif.psrc1_2 !== 6'd0) begin tests_failed++;
            $display("FAIL r0_nobyp got %0d want 0", rif.psrc1_2); end
        lookup(5'd0, 5'd0);
        tests_run++;
        if (rif.psrc1_1 !== 6'd0) begin tests_failed++;
            $display("FAIL r0_lookup got %0d want 0", rif.psrc1_1); end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_basic();
        test_bypass();
        test_back_to_back();
        test_alloc_block();
        test_stall();
        test_prmiss_commit();
        test_r0();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/rename_table.md
# rename_table

Two-wide speculative register alias table for the rename stage, directly downstream of the physical-tag freelist. Each cycle it translates up to two instructions' architectural source/destination registers to physical tags, installs the freelist's newly allocated tags as destination mappings, and returns each destination's previous tag for release at commit. A committed copy of the table, updated by the commit stage, restores the speculative table on branch misprediction. Results are registered and presented to dispatch one cycle later.

## Interface
- NUM_ARCH, 32, architectural registers
- ARCH_SEL, 5, architectural index width
- PHYS_NUM, 64, physical tags
- PHYS_SEL, 6, physical tag width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall  in  1  dispatch/freelist backpressure; no state update, outputs hold
- prmiss  in  1  branch mispredict; restore speculative table
- valid_1, valid_2  in  1  rename slot valid (slot 1 older)
- wr_1, wr_2  in  1  slot writes a destination; also drives freelist request
- src1_1, src2_1, dst_1, src1_2, src2_2, dst_2  in  ARCH_SEL  architectural operands
- alloc_1, alloc_2  in  PHYS_SEL  tags from freelist
- alloc_valid_1, alloc_valid_2  in  1  freelist tag valid
- com_valid_1, com_valid_2  in  1  commit port valid (port 1 older)
- com_dst_1, com_dst_2  in  ARCH_SEL  committed destination
- com_tag_1, com_tag_2  in  PHYS_SEL  committed physical tag
- out_valid_1, out_valid_2  out  1  registered rename result valid
- psrc1_1, psrc2_1, pdst_1, pold_1, psrc1_2, psrc2_2, pdst_2, pold_2  out  PHYS_SEL  registered physical source, new destination, previous destination tags

## Operation
- Two arrays: spec_map and com_map, NUM_ARCH entries of PHYS_SEL bits.
- Architectural register 0 is hard-mapped to tag 0; reads of r0 return 0; wr_i with dst_i==0 is treated as wr_i=0 (no table write, pold_i=0, pdst_i=0).
- fire_1 = valid_1 & ~stall & ~prmiss & (~wr_1 | alloc_valid_1).
- fire_2 = valid_2 & ~stall & ~prmiss & (~wr_2 | alloc_valid_2) & (fire_1 | ~valid_1); slot 2 never fires past a blocked slot 1.
- Slot 1: psrc = spec_map[src]; pold_1 = spec_map[dst_1]; pdst_1 = alloc_1 if wr_1 else 0.
- Slot 2 intra-group bypass: if fire_1 & wr_1 & src==dst_1 then psrc = alloc_1, else spec_map[src]; pold_2 likewise = alloc_1 if dst_2==dst_1 & wr_1 & fire_1, else spec_map[dst_2].
- Table write on fire_i & wr_i: spec_map[dst_i] <= alloc_i; same dst in both slots: slot 2 wins.
- Commit: com_valid_i writes com_map[com_dst_i] <= com_tag_i regardless of stall; same dst on both ports: port 2 wins.
- prmiss: spec_map <= com_map including this cycle's commit writes (bypassed); all rename writes suppressed; out_valid_1/2 <= 0.
- Commit and prmiss are independent of stall.

## Timing
- Reset: spec_map[r] = com_map[r] = r for all r; out_valid_1/2 = 0; all tag outputs = 0. Integration requirement: freelist tags 0..NUM_ARCH-1 are not free after reset.
- Lookup uses pre-edge spec_map; results registered at next posedge (latency 1).
- stall=1 & prmiss=0: output registers and spec_map hold; commit still updates com_map.
- Not stalled: out_valid_i <= fire_i; tag outputs loaded when fire_i, else hold.
- Rename at cycle N of dst r observed by lookup at cycle N+1 (no combinational read-after-write across cycles needed beyond the array).
- prmiss has priority over stall and rename; reset has priority over everything.
- Misprediction restore completes in one cycle; rename resumes in cycle N+1 using restored map.

## Test plan
- Reset, then rename slot1 src1=3,src2=4 wr=0 -> next cycle out_valid_1=1, psrc1_1=3, psrc2_1=4.
- Slot1 wr dst=5 alloc=40, slot2 src1=5 dst=5 alloc=41 -> psrc1_2=40, pold_1=5, pold_2=40; then lookup src 5 -> 41.
- valid_1=1 wr_1=1 alloc_valid_1=0, valid_2=1 wr_2=0 -> out_valid_1=out_valid_2=0, spec_map unchanged.
- stall=1 with both slots valid and com_valid_1 dst=7 tag=50 -> outputs hold, spec unchanged; later prmiss -> lookup r7 = 50.
- Rename dst=9 alloc=45 (uncommitted), commit dst=2 tag=33 same cycle as prmiss -> next lookup r9=9, r2=33, out_valid=0.
- wr_1=1 dst=0 alloc=44 -> pdst_1=0, pold_1=0, lookup r0 still 0.
